float_sub: RTL and testbench



---
 rtl/float_pkg.sv | 44 ++++
 rtl/float_align_shift.sv | 38 +++
 rtl/float_sub.sv | 166 ++++++++++++++++
 tb/tb_float_sub.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : float_pkg
// Description : Shared single-precision float constants, field helpers and
//               sequencer state encodings for float_mul / float_sub.
// Revision    : 1.0
//------------------------------------------------------------------------------
package float_pkg;

    localparam int WORD_W  = 32;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 254;
    localparam int MANT_W  = FRAC_W + 4;   // hidden + fraction + G/R/S
    localparam int SEXP_W  = 10;           // signed exponent, headroom both ways

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_ADDSUB = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    function automatic logic f_sign(input logic [WORD_W-1:0] f);
        return f[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [WORD_W-1:0] f);
        return f[WORD_W-2 -: EXP_W];
    endfunction

    // Zero exponent flushes the operand to zero, fraction ignored.
    function automatic logic [MANT_W-1:0] f_mant(input logic [WORD_W-1:0] f);
        if (f[WORD_W-2 -: EXP_W] == '0)
            return '0;
        else
            return {1'b1, f[FRAC_W-1:0], 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_align_shift.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : float_align_shift
// Description : Combinational right shift of the 27-bit mantissa; bits shifted
//               out are OR-ed into the sticky position.
// Revision    : 1.0
//------------------------------------------------------------------------------
module float_align_shift
    import float_pkg::*;
(
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_shamt,
    output logic [MANT_W-1:0] o_mant
);

    localparam logic [EXP_W-1:0] c_max_shift = EXP_W'(MANT_W);

    logic [MANT_W-1:0] w_shifted;
    logic [MANT_W-1:0] w_mask;
    logic              w_sticky;

    always_comb begin
        w_shifted = '0;
        w_mask    = '0;
        w_sticky  = 1'b0;
        o_mant    = '0;
        if (i_shamt >= c_max_shift) begin
            o_mant = {{(MANT_W-1){1'b0}}, |i_mant};
        end else begin
            w_shifted = i_mant >> i_shamt;
            w_mask    = ~({MANT_W{1'b1}} << i_shamt);
            w_sticky  = |(i_mant & w_mask);
            o_mant    = {w_shifted[MANT_W-1:1], w_shifted[0] | w_sticky};
        end
    end

endmodule
`default_nettype wire

// File: rtl/float_sub.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : float_sub
// Description : Multi-cycle single-precision subtractor, float_out = A - B,
//               with start/ready handshake matching float_mul.
// Revision    : 1.0
//------------------------------------------------------------------------------
module float_sub
    import float_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] float_in_1,
    input  logic [WORD_W-1:0] float_in_2,
    output logic [WORD_W-1:0] float_out,
    output logic              ready
);

    localparam logic signed [SEXP_W-1:0] c_exp_ovf = SEXP_W'(EXP_MAX);
    localparam logic signed [SEXP_W-1:0] c_exp_unf = SEXP_W'(1);

    state_t r_state;
    state_t w_state_next;

    logic [WORD_W-1:0]        r_a;
    logic [WORD_W-1:0]        r_b;
    logic                     r_sign;
    logic                     r_eff_sub;
    logic signed [SEXP_W-1:0] r_exp;
    logic [MANT_W-1:0]        r_mant_l;
    logic [MANT_W-1:0]        r_mant_s;
    logic [MANT_W:0]          r_mant;     // carry bit on top

    logic [EXP_W-1:0]  w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_shamt;
    logic [MANT_W-1:0] w_mant_a, w_mant_b, w_mant_l, w_mant_s_raw, w_mant_s_al;
    logic              w_a_ge_b, w_sign_l, w_sign_s;
    logic [MANT_W:0]   w_sum;
    logic              w_sum_zero;
    logic [FRAC_W+1:0] w_rnd;
    logic [WORD_W-1:0] w_result;

    // Operand ordering so the magnitude subtraction never goes negative.
    always_comb begin
        w_exp_a      = f_exp(r_a);
        w_exp_b      = f_exp(r_b);
        w_mant_a     = f_mant(r_a);
        w_mant_b     = f_mant(r_b);
        w_a_ge_b     = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};
        w_exp_l      = w_a_ge_b ? w_exp_a  : w_exp_b;
        w_exp_s      = w_a_ge_b ? w_exp_b  : w_exp_a;
        w_mant_l     = w_a_ge_b ? w_mant_a : w_mant_b;
        w_mant_s_raw = w_a_ge_b ? w_mant_b : w_mant_a;
        w_sign_l     = w_a_ge_b ? f_sign(r_a) : f_sign(r_b);
        w_sign_s     = w_a_ge_b ? f_sign(r_b) : f_sign(r_a);
        w_shamt      = w_exp_l - w_exp_s;
    end

    float_align_shift u_align_shift (
        .i_mant  (w_mant_s_raw),
        .i_shamt (w_shamt),
        .o_mant  (w_mant_s_al)
    );

    always_comb begin
        w_sum      = r_eff_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                               : ({1'b0, r_mant_l} + {1'b0, r_mant_s});
        w_sum_zero = (w_sum == '0);
        w_rnd      = {1'b0, r_mant[MANT_W-1:3]} + {{(FRAC_W+1){1'b0}}, r_mant[2]};
        if (r_exp > c_exp_ovf)
            w_result = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (r_exp < c_exp_unf)
            w_result = '0;
        else
            w_result = {r_sign, r_exp[EXP_W-1:0], r_mant[MANT_W-2:3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_ALIGN;
            ST_ALIGN:  w_state_next = ST_ADDSUB;
            ST_ADDSUB: w_state_next = w_sum_zero ? ST_FINISH : ST_NORM;
            ST_NORM: begin
                if (r_mant[MANT_W] || r_mant[MANT_W-1])
                    w_state_next = ST_ROUND;
            end
            ST_ROUND:  w_state_next = ST_FINISH;
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= '0;
            r_mant_l  <= '0;
            r_mant_s  <= '0;
            r_mant    <= '0;
            float_out <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a <= float_in_1;
                        r_b <= {~float_in_2[WORD_W-1], float_in_2[WORD_W-2:0]};
                    end
                end
                ST_ALIGN: begin
                    r_sign    <= w_sign_l;
                    r_eff_sub <= w_sign_l ^ w_sign_s;
                    r_exp     <= {2'b00, w_exp_l};
                    r_mant_l  <= w_mant_l;
                    r_mant_s  <= w_mant_s_al;
                end
                ST_ADDSUB: begin
                    if (w_sum_zero) begin
                        r_sign <= 1'b0;
                        r_exp  <= '0;
                        r_mant <= '0;
                    end else begin
                        r_mant <= w_sum;
                    end
                end
                ST_NORM: begin
                    if (r_mant[MANT_W]) begin
                        r_mant <= {1'b0, r_mant[MANT_W:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + 10'sd1;
                    end else if (!r_mant[MANT_W-1]) begin
                        r_mant <= {r_mant[MANT_W-1:0], 1'b0};
                        r_exp  <= r_exp - 10'sd1;
                    end
                end
                ST_ROUND: begin
                    // Rounding up out of 1.111.. yields exactly 1.0 one binade higher.
                    if (w_rnd[FRAC_W+1]) begin
                        r_mant <= {2'b01, {(MANT_W-1){1'b0}}};
                        r_exp  <= r_exp + 10'sd1;
                    end else begin
                        r_mant <= {1'b0, w_rnd[FRAC_W:0], 3'b000};
                    end
                end
                ST_FINISH: begin
                    float_out <= w_result;
                    ready     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_sub.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_float_sub
// Description : Scoreboard bench for float_sub with directed vectors.
// Revision    : 1.0
//------------------------------------------------------------------------------
module tb_float_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] float_in_1 = '0;
    logic [31:0] float_in_2 = '0;
    logic [31:0] float_out;
    logic        ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_cnt = 0;

    logic [31:0] exp_res[$];
    int          exp_lat[$];
    int          exp_iss[$];
    int          exp_id[$];

    float_sub dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .float_in_1 (float_in_1),
        .float_in_2 (float_in_2),
        .float_out  (float_out),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare each time the DUT presents a result.
    always begin
        logic [31:0] e_res;
        int e_lat, e_iss, e_id;
        @(posedge clk);
        #1;
        if (ready === 1'b1) begin
            ready_cnt++;
            if (exp_res.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ready: got float_out=%h with no request pending", float_out);
            end else begin
                e_res = exp_res.pop_front();
                e_lat = exp_lat.pop_front();
                e_iss = exp_iss.pop_front();
                e_id  = exp_id.pop_front();
                total++;
                if (float_out !== e_res) begin
                    bad++;
                    $display("FAIL result_%0d: got %h expected %h", e_id, float_out, e_res);
                end
                if (e_lat > 0) begin
                    total++;
                    if (cyc - e_iss != e_lat) begin
                        bad++;
                        $display("FAIL latency_%0d: got %0d expected %0d", e_id, cyc - e_iss, e_lat);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] res, input int lat, input int id);
        exp_res.push_back(res);
        exp_lat.push_back(lat);
        exp_iss.push_back(cyc + 1);
        exp_id.push_back(id);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input int id);
        @(negedge clk);
        float_in_1 = a;
        float_in_2 = b;
        start      = 1'b1;
        push_exp(res, lat, id);
        @(negedge clk);
        start      = 1'b0;
        float_in_1 = $urandom;
        float_in_2 = $urandom;
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (exp_res.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_res.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout_%0d: %0d results still pending, expected 0", id, exp_res.size());
            exp_res.delete(); exp_lat.delete(); exp_iss.delete(); exp_id.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int n;
        repeat (3) @(negedge clk);
        total++;
        if (float_out !== 32'h0) begin bad++; $display("FAIL reset_out: got %h expected 00000000", float_out); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        rst = 1'b0;

        send(32'h3FC00000, 32'h3F000000, 32'h3F800000, 5, 1);  drain(1);   // 1.5-0.5
        send(32'h3F800000, 32'h3F400000, 32'h3E800000, 7, 2);  drain(2);   // k=2
        send(32'h40000000, 32'h40000000, 32'h00000000, 3, 3);  drain(3);   // zero path
        send(32'h3F000000, 32'h3FC00000, 32'hBF800000, 5, 4);  drain(4);   // negative
        send(32'h3F800000, 32'hBF800000, 32'h40000000, 5, 5);  drain(5);   // carry
        send(32'h3F800000, 32'h33000000, 32'h3F800000, 6, 6);  drain(6);   // round ovf
        send(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5, 7);  drain(7);   // overflow
        send(32'h00800000, 32'h00400000, 32'h00800000, 5, 8);  drain(8);   // denormal B
        send(32'h00C00000, 32'h00800000, 32'h00000000, 6, 9);  drain(9);   // underflow
        send(32'h3F800000, 32'hB3800000, 32'h3F800001, 5, 10); drain(10);  // tie away
        send(32'h40490FDB, 32'h00000000, 32'h40490FDB, 5, 11); drain(11);  // d>=27
        send(32'h00000000, 32'h3F800000, 32'hBF800000, 5, 12); drain(12);  // 0-x
        send(32'h40400000, 32'h3F800000, 32'h40000000, 5, 13); drain(13);  // 3-1

        // start pulsed while in ADDSUB must be ignored
        cnt0 = ready_cnt;
        @(negedge clk);
        float_in_1 = 32'h3FC00000; float_in_2 = 32'h3F000000; start = 1'b1;
        push_exp(32'h3F800000, 5, 14);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; float_in_1 = 32'h40000000; float_in_2 = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        drain(14);
        repeat (12) @(negedge clk);
        total++;
        if (ready_cnt - cnt0 != 1) begin
            bad++; $display("FAIL ignored_start_pulses: got %0d ready pulses expected 1", ready_cnt - cnt0);
        end

        // reset asserted during NORM aborts the operation
        @(negedge clk);
        float_in_1 = 32'h3F800000; float_in_2 = 32'h3F400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (float_out !== 32'h0) begin bad++; $display("FAIL abort_out: got %h expected 00000000", float_out); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b expected 0", ready); end
        cnt0 = ready_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (ready_cnt != cnt0) begin
            bad++; $display("FAIL abort_no_ready: got %0d pulses expected 0", ready_cnt - cnt0);
        end

        // back-to-back: new start right after ready
        send(32'h3F800000, 32'h3F400000, 32'h3E800000, 7, 15);
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL b2b_wait: ready got %b expected 1", ready);
        end
        send(32'h3F000000, 32'h3FC00000, 32'hBF800000, 5, 16);
        drain(16);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
